// File: rtl/duart_access_ctrl.sv
// Purpose: 6809 bus-cycle sequencer for an MC68681 DUART: window decode, CS_B, data buffer control, DTACK timeout.
// Latency: cs_b falls on the clk sampling Q rise; mrdy rises 3 clk after dtack_b falls; cs_b rises on the clk sampling E fall.
// Backpressure: holds the CPU off through MRDY while recovery is pending or until DTACK (or timeout) arrives.
module duart_access_ctrl #(
    parameter logic [15:0] BASE_ADDR    = 16'hFE00,
    parameter logic [15:0] ADDR_MASK    = 16'hFFF0,
    parameter int          RECOVERY_CYC = 6,
    parameter int          TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] addr,
    input  logic        rnw,
    input  logic        eclk,
    input  logic        qclk,
    input  logic        ba,
    input  logic        dtack_b,
    input  logic        err_clr,
    output logic        cs_b,
    output logic        mrdy,
    output logic        dbuf_en_b,
    output logic        dbuf_dir,
    output logic        busy,
    output logic        timeout_err
);

    localparam int REC_W = $clog2(RECOVERY_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVERY_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECWAIT = 2'd1,
        ACCESS  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t state, next_state;

    logic             qclk_d, eclk_d;
    logic             dtack_s1, dtack_s2;
    logic [REC_W-1:0] rec_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic q_rise, e_fall, addr_hit, start;
    logic rec_done, dtack_seen, tmo_hit, tmo_abort;
    logic cs_b_nxt, mrdy_nxt, dbuf_en_b_nxt, dbuf_dir_nxt, busy_nxt, timeout_err_nxt;

    assign q_rise     = qclk & ~qclk_d;
    assign e_fall     = ~eclk & eclk_d;
    // The address is only decoded at the start instant, so later bus changes cannot affect the cycle.
    assign addr_hit   = ((addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign start      = q_rise & ~ba & addr_hit;
    // The count is loaded on the same clk cs_b rises, so a value of 1 means the
    // recovery window expires on this clk and the next cs_b fall may land here.
    assign rec_done   = (rec_cnt <= REC_W'(1));
    assign dtack_seen = ~dtack_s2;
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    // A DTACK arriving on the final timeout clk still counts as a normal completion.
    assign tmo_abort  = (state == ACCESS) & ~dtack_seen & tmo_hit;

    // Edge detect history and DTACK synchroniser; qclk_d resets high so a Q
    // already high at reset release is not mistaken for a fresh rise.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            qclk_d   <= 1'b1;
            eclk_d   <= 1'b0;
            dtack_s1 <= 1'b1;
            dtack_s2 <= 1'b1;
        end else begin
            qclk_d   <= qclk;
            eclk_d   <= eclk;
            dtack_s1 <= dtack_b;
            dtack_s2 <= dtack_s1;
        end
    end

    // Recovery counter (loaded as cs_b rises) and DTACK timeout counter (runs only in ACCESS).
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rec_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == HOLD && e_fall) begin
                rec_cnt <= REC_LOAD;
            end else if (rec_cnt != '0) begin
                rec_cnt <= rec_cnt - 1'b1;
            end
            if (state != ACCESS) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; Q rises outside IDLE are ignored since E is still stretched.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = rec_done ? ACCESS : RECWAIT;
                end
            end
            RECWAIT: begin
                if (rec_done) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (dtack_seen || tmo_hit) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (e_fall) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop with no input-to-output path.
    always_comb begin
        cs_b_nxt        = ~((next_state == ACCESS) || (next_state == HOLD));
        dbuf_en_b_nxt   = cs_b_nxt;
        mrdy_nxt        = ~((next_state == RECWAIT) || (next_state == ACCESS));
        busy_nxt        = (next_state != IDLE);
        dbuf_dir_nxt    = (state == IDLE && start) ? rnw : dbuf_dir;
        timeout_err_nxt = tmo_abort | (timeout_err & ~err_clr);
    end

    // Output registers; reset releases the bus immediately, even mid-cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_b        <= 1'b1;
            mrdy        <= 1'b1;
            dbuf_en_b   <= 1'b1;
            dbuf_dir    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cs_b        <= cs_b_nxt;
            mrdy        <= mrdy_nxt;
            dbuf_en_b   <= dbuf_en_b_nxt;
            dbuf_dir    <= dbuf_dir_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_duart_access_ctrl.sv
// Purpose: self-checking bench for duart_access_ctrl against a cycle-arithmetic reference model.
// Latency: expected edges derived from start/recovery/DTACK timing rules.
// Backpressure: the bus model holds E high until mrdy is seen high.
module tb_duart_access_ctrl;

    localparam int REC = 6;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        rnw = 1'b0;
    logic        eclk = 1'b0;
    logic        qclk = 1'b0;
    logic        ba = 1'b0;
    logic        dtack_b = 1'b1;
    logic        err_clr = 1'b0;
    logic        cs_b, mrdy, dbuf_en_b, dbuf_dir, busy, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Edge indices of the last observed output transitions (-1 = none this cycle).
    int cs_fall_e = -1, cs_rise_e = -1, mrdy_fall_e = -1, mrdy_rise_e = -1, busy_rise_e = -1;
    int inv_bad = 0;
    logic exp_dir = 1'b0;
    logic p_cs = 1'b1, p_mrdy = 1'b1, p_busy = 1'b0;

    // Reference model state: clk index of the last cs_b rise, sticky error.
    int   m_last_rise = -1000;
    logic m_err = 1'b0;

    duart_access_ctrl #(
        .BASE_ADDR   (16'hFE00),
        .ADDR_MASK   (16'hFFF0),
        .RECOVERY_CYC(REC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .addr       (addr),
        .rnw        (rnw),
        .eclk       (eclk),
        .qclk       (qclk),
        .ba         (ba),
        .dtack_b    (dtack_b),
        .err_clr    (err_clr),
        .cs_b       (cs_b),
        .mrdy       (mrdy),
        .dbuf_en_b  (dbuf_en_b),
        .dbuf_dir   (dbuf_dir),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Monitor: record transition edges and track bus-level invariants, sampled 1 ns after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (p_cs === 1'b1 && cs_b === 1'b0) cs_fall_e = cyc;
        if (p_cs === 1'b0 && cs_b === 1'b1) cs_rise_e = cyc;
        if (p_mrdy === 1'b1 && mrdy === 1'b0) mrdy_fall_e = cyc;
        if (p_mrdy === 1'b0 && mrdy === 1'b1) mrdy_rise_e = cyc;
        if (p_busy === 1'b0 && busy === 1'b1) busy_rise_e = cyc;
        if (cs_b === 1'b0 && dbuf_dir !== exp_dir) inv_bad++;
        if (dbuf_en_b !== cs_b) inv_bad++;
        if (busy !== (!mrdy || !cs_b)) inv_bad++;
        p_cs = cs_b;
        p_mrdy = mrdy;
        p_busy = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One 6809 bus cycle: Q rises (start), E rises, Q falls and the bus is scrambled,
    // DTACK asserted dly clk after cs_b falls (dly<0: never), E held until mrdy high, then E falls.
    task automatic bus_cycle(input logic [15:0] a, input logic r, input logic b, input int dly,
                             input int hold, input int clr_off, output int start_e, output int efall_e);
        logic hit;
        logic done;
        int   n;
        int   j;
        hit = !b && ((a & 16'hFFF0) == 16'hFE00);
        cs_fall_e = -1; cs_rise_e = -1; mrdy_fall_e = -1; mrdy_rise_e = -1; busy_rise_e = -1;
        exp_dir = r;
        addr = a; rnw = r; ba = b; qclk = 1'b1;
        start_e = cyc + 1;
        n = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            if (n >= 2 && (hit ? (mrdy_rise_e >= 0) : (n >= 4))) begin
                done = 1'b1;
            end else begin
                if (n == 1) eclk = 1'b1;
                if (n == 2) begin
                    qclk = 1'b0;
                    addr = 16'($urandom);
                    rnw  = ~r;
                    ba   = 1'($urandom);
                end
                if (cs_fall_e >= 0) begin
                    j = cyc - cs_fall_e;
                    dtack_b = !(dly >= 0 && j >= dly);
                    err_clr = (j == clr_off - 1);
                end
                step(1);
                n++;
            end
        end
        err_clr = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL bus_cycle_bound: no completion after %0d clk, required completion", n);
        end
        step(hold);
        eclk = 1'b0;
        efall_e = cyc + 1;
        step(1);
        dtack_b = 1'b1;
        ba = 1'b0;
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (cs_b !== 1'b1) begin errors++; $display("FAIL rst_cs_b: got %b want 1", cs_b); end
        checks++; if (mrdy !== 1'b1) begin errors++; $display("FAIL rst_mrdy: got %b want 1", mrdy); end
        checks++; if (dbuf_en_b !== 1'b1) begin errors++; $display("FAIL rst_dbuf_en_b: got %b want 1", dbuf_en_b); end
        checks++; if (dbuf_dir !== 1'b0) begin errors++; $display("FAIL rst_dbuf_dir: got %b want 0", dbuf_dir); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        reset_b = 1'b1;
        step(2);
    endtask

    task automatic test_read;
        int s, e, f;
        bus_cycle(16'hFE05, 1'b1, 1'b0, 4, 1, -100, s, e);
        f = max2(s, m_last_rise + REC);
        checks++; if (cs_fall_e !== f) begin errors++; $display("FAIL read_cs_fall: got %0d want %0d", cs_fall_e, f); end
        checks++; if (mrdy_fall_e !== s) begin errors++; $display("FAIL read_mrdy_fall: got %0d want %0d", mrdy_fall_e, s); end
        checks++; if (mrdy_rise_e !== f + 4 + 3) begin errors++; $display("FAIL read_mrdy_rise: got %0d want %0d", mrdy_rise_e, f + 7); end
        checks++; if (cs_rise_e !== e) begin errors++; $display("FAIL read_cs_rise: got %0d want %0d", cs_rise_e, e); end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL read_bus_invariants: got %0d violations want 0", inv_bad); end
        m_last_rise = e;
    endtask

    task automatic test_back_to_back;
        int s1, e1, s2, e2, f;
        bus_cycle(16'hFE00, 1'b0, 1'b0, 2, 0, -100, s1, e1);
        f = max2(s1, m_last_rise + REC);
        checks++; if (cs_fall_e !== f) begin errors++; $display("FAIL b2b_first_cs_fall: got %0d want %0d", cs_fall_e, f); end
        checks++; if (cs_rise_e !== e1) begin errors++; $display("FAIL b2b_first_cs_rise: got %0d want %0d", cs_rise_e, e1); end
        m_last_rise = e1;
        step(1);
        bus_cycle(16'hFE01, 1'b0, 1'b0, 3, 0, -100, s2, e2);
        checks++; if (mrdy_fall_e !== e1 + 2) begin errors++; $display("FAIL b2b_mrdy_fall: got %0d want %0d", mrdy_fall_e, e1 + 2); end
        checks++; if (cs_fall_e !== e1 + REC) begin errors++; $display("FAIL b2b_recovery: got %0d want %0d", cs_fall_e, e1 + REC); end
        checks++; if (cs_fall_e - mrdy_fall_e !== 4) begin errors++; $display("FAIL b2b_recwait_len: got %0d want 4", cs_fall_e - mrdy_fall_e); end
        checks++; if (mrdy_rise_e !== e1 + REC + 3 + 3) begin errors++; $display("FAIL b2b_mrdy_rise: got %0d want %0d", mrdy_rise_e, e1 + REC + 6); end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL b2b_bus_invariants: got %0d violations want 0", inv_bad); end
        m_last_rise = e2;
    endtask

    task automatic test_no_match;
        logic [15:0] list [2];
        int s, e;
        list[0] = 16'hFE10;
        list[1] = 16'hFD0F;
        for (int i = 0; i < 2; i++) begin
            bus_cycle(list[i], 1'($urandom), 1'b0, 0, 0, -100, s, e);
            checks++; if (cs_fall_e !== -1) begin errors++; $display("FAIL nomatch_cs %h: cs_b fell at %0d want never", list[i], cs_fall_e); end
            checks++; if (mrdy_fall_e !== -1) begin errors++; $display("FAIL nomatch_mrdy %h: mrdy fell at %0d want never", list[i], mrdy_fall_e); end
            checks++; if (busy_rise_e !== -1) begin errors++; $display("FAIL nomatch_busy %h: busy rose at %0d want never", list[i], busy_rise_e); end
        end
    endtask

    task automatic test_ba;
        int s, e;
        bus_cycle(16'hFE03, 1'b1, 1'b1, 0, 0, -100, s, e);
        checks++; if (cs_fall_e !== -1) begin errors++; $display("FAIL ba_cs: cs_b fell at %0d want never", cs_fall_e); end
        checks++; if (mrdy_fall_e !== -1) begin errors++; $display("FAIL ba_mrdy: mrdy fell at %0d want never", mrdy_fall_e); end
        checks++; if (busy_rise_e !== -1) begin errors++; $display("FAIL ba_busy: busy rose at %0d want never", busy_rise_e); end
    endtask

    task automatic test_timeout;
        int s, e, f;
        bus_cycle(16'hFE02, 1'b1, 1'b0, -1, 2, -100, s, e);
        f = max2(s, m_last_rise + REC);
        m_err = 1'b1;
        checks++; if (cs_fall_e !== f) begin errors++; $display("FAIL tmo_cs_fall: got %0d want %0d", cs_fall_e, f); end
        checks++; if (mrdy_rise_e !== f + TMO) begin errors++; $display("FAIL tmo_mrdy_rise: got %0d want %0d", mrdy_rise_e, f + TMO); end
        checks++; if (cs_rise_e !== e) begin errors++; $display("FAIL tmo_cs_rise: got %0d want %0d", cs_rise_e, e); end
        checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL tmo_err_set: got %b want %b", timeout_err, m_err); end
        m_last_rise = e;
        step(3);
        checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL tmo_err_sticky: got %b want %b", timeout_err, m_err); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL tmo_err_clear: got %b want %b", timeout_err, m_err); end
        bus_cycle(16'hFE0A, 1'b0, 1'b0, -1, 0, TMO, s, e);
        f = max2(s, m_last_rise + REC);
        m_err = 1'b1;
        checks++; if (mrdy_rise_e !== f + TMO) begin errors++; $display("FAIL tmo2_mrdy_rise: got %0d want %0d", mrdy_rise_e, f + TMO); end
        checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL tmo2_set_over_clr: got %b want %b", timeout_err, m_err); end
        m_last_rise = e;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic        r, b, hit;
        int          dly, s, e, f;
        for (int it = 0; it < 24; it++) begin
            step(int'($urandom_range(0, 8)));
            if ($urandom_range(0, 7) < 5) begin
                a = 16'hFE00 | 16'($urandom_range(0, 15));
            end else begin
                a = 16'($urandom);
            end
            r   = 1'($urandom);
            b   = ($urandom_range(0, 7) == 0);
            dly = int'($urandom_range(0, 8));
            hit = !b && (a[15:4] == 12'hFE0);
            bus_cycle(a, r, b, dly, int'($urandom_range(0, 3)), -100, s, e);
            f = hit ? max2(s, m_last_rise + REC) : -1;
            checks++; if (cs_fall_e !== f) begin errors++; $display("FAIL rnd%0d_cs_fall a=%h: got %0d want %0d", it, a, cs_fall_e, f); end
            checks++; if (mrdy_fall_e !== (hit ? s : -1)) begin errors++; $display("FAIL rnd%0d_mrdy_fall a=%h: got %0d want %0d", it, a, mrdy_fall_e, hit ? s : -1); end
            checks++; if (mrdy_rise_e !== (hit ? f + dly + 3 : -1)) begin errors++; $display("FAIL rnd%0d_mrdy_rise a=%h: got %0d want %0d", it, a, mrdy_rise_e, hit ? f + dly + 3 : -1); end
            checks++; if (cs_rise_e !== (hit ? e : -1)) begin errors++; $display("FAIL rnd%0d_cs_rise a=%h: got %0d want %0d", it, a, cs_rise_e, hit ? e : -1); end
            checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd%0d_timeout_err: got %b want %b", it, timeout_err, m_err); end
            if (hit) m_last_rise = e;
        end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL rnd_bus_invariants: got %0d violations want 0", inv_bad); end
    endtask

    task automatic test_reset_mid;
        int s, e;
        step(REC);
        cs_fall_e = -1;
        addr = 16'hFE07; rnw = 1'b1; ba = 1'b0; exp_dir = 1'b1;
        qclk = 1'b1;
        step(1);
        eclk = 1'b1;
        step(1);
        qclk = 1'b0;
        step(2);
        checks++; if (cs_b !== 1'b0) begin errors++; $display("FAIL rstmid_pre_cs_b: got %b want 0", cs_b); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
        #3;
        reset_b = 1'b0;
        #1;
        checks++; if (cs_b !== 1'b1) begin errors++; $display("FAIL rstmid_cs_b: got %b want 1", cs_b); end
        checks++; if (mrdy !== 1'b1) begin errors++; $display("FAIL rstmid_mrdy: got %b want 1", mrdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        eclk = 1'b0;
        step(2);
        reset_b = 1'b1;
        m_last_rise = -1000;
        m_err = 1'b0;
        step(1);
        bus_cycle(16'hFE04, 1'b0, 1'b0, 1, 0, -100, s, e);
        checks++; if (cs_fall_e !== s) begin errors++; $display("FAIL rstmid_no_recovery: got %0d want %0d", cs_fall_e, s); end
        checks++; if (mrdy_rise_e !== s + 1 + 3) begin errors++; $display("FAIL rstmid_mrdy_rise: got %0d want %0d", mrdy_rise_e, s + 4); end
        m_last_rise = e;
    endtask

    initial begin
        #1;
        reset_b = 1'b0;
        test_reset();
        test_read();
        test_back_to_back();
        test_no_match();
        test_ba();
        test_timeout();
        test_random();
        test_reset_mid();
        checks++;
        if (inv_bad !== 0) begin
            errors++;
            $display("FAIL final_bus_invariants: got %0d violations want 0", inv_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
